uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Receive-side frame decoder for the host UART link. Pops bytes from a UART receive FIFO, finds 0xEB 0x90 framed commands, checks length and checksum, and streams the payload to an external buffer. It reports good and bad frames and decodes the baud-rate command into the `latch_baud`/`baud_word` pair used by the uart block. One instance sits beside each uart instance, running on the 110.592 MHz system clock `clk`.

## Interface
- HDR0, 8'hEB, first sync byte
- HDR1, 8'h90, second sync byte
- MAX_LEN, 32, largest legal payload length in bytes (1..255)
- CMD_BAUD, 8'h01, command code that carries a new baud word
- TIMEOUT, 16'd50000, maximum inter-byte gap inside a frame, in clk cycles
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low
- rx_fifo_empty  in  1  receive FIFO empty
- rx_fifo_ren  out  1  receive FIFO read strobe
- rx_fifo_rdata  in  8  FIFO data, valid the cycle after `rx_fifo_ren`
- pl_wen  out  1  payload byte write strobe
- pl_waddr  out  8  payload byte index, counting from 0 within the frame
- pl_wdata  out  8  payload byte
- cmd_valid  out  1  one-cycle pulse: a good frame has completed
- cmd_code  out  8  command byte of the last good frame
- cmd_len  out  8  payload length of the last good frame
- cmd_err  out  1  one-cycle pulse: a frame was rejected
- err_code  out  2  rejection cause: 1 = checksum, 2 = length, 3 = timeout
- latch_baud  out  1  one-cycle pulse that loads `baud_word` into the uart
- baud_word  out  16  baud divisor word
- frame_cnt  out  16  count of good frames, saturates at 16'hFFFF
- err_cnt  out  16  count of rejected frames, saturates at 16'hFFFF

## Operation
- Read engine
  - At most one read is outstanding at a time.
  - `rx_fifo_ren` pulses when `!rx_fifo_empty` and no read is pending.
  - The byte is consumed the following cycle; that cycle is called "byte event".
  - Maximum rate is one byte every 2 cycles.
- State machine: H0, H1, CMD, LEN, PAY, CSUM. Each state acts only on a byte event.
  - H0: byte == HDR0 -> H1; otherwise stay in H0.
  - H1: byte == HDR1 -> CMD; byte == HDR0 -> stay in H1; otherwise -> H0.
  - CMD: store the code, set the running sum to the byte -> LEN.
  - LEN:
    - Add the byte to the sum.
    - len > MAX_LEN -> `cmd_err` with err_code 2, then H0.
    - len == 0 -> CSUM.
    - Otherwise -> PAY.
  - PAY: for each byte, assert `pl_wen`, `pl_waddr` = index, `pl_wdata` = byte, and add it to the sum. After the byte with index len-1 -> CSUM.
  - CSUM:
    - Byte == sum[7:0] -> `cmd_valid` and `frame_cnt`+1.
    - Otherwise -> `cmd_err` with err_code 1 and `err_cnt`+1.
    - Both cases return to H0.
- Checksum: 8-bit modulo sum of cmd, len and all payload bytes. The sync bytes are not included.
- Baud decode
  - Applies to a good frame with cmd == CMD_BAUD and len == 2.
  - `baud_word` = {payload0, payload1} (big-endian).
  - `latch_baud` pulses in the same cycle as `cmd_valid`.
  - Any other length with CMD_BAUD is a good frame but gives no `latch_baud`.
- Rejected frames
  - Payload bytes already written stay in the external buffer.
  - The consumer must act only on `cmd_valid`.
- `cmd_code`, `cmd_len` and `baud_word` hold their values until the next good frame or reset.
- Length rejection also increments `err_cnt`.

## Timing
- Reset value of every output is 0; the FSM resets to H0.
- A reset asserted mid-frame drops the frame with no error pulse. A read that was pending is discarded.
- `pl_wen` is registered: it asserts 1 cycle after the byte event of that payload byte.
- `cmd_valid`, `cmd_err` and `latch_baud` are registered: they assert 1 cycle after the CSUM (or LEN) byte event, each high for exactly 1 cycle.
- Latency from the checksum byte's `rx_fifo_ren` to `cmd_valid` is 2 cycles.
- A new frame's H0 byte may be consumed in the same cycle that `cmd_valid` is high.
- FIFO empty mid-frame: the FSM stalls with no error (subject to the timeout below).
- Counter saturation: an increment at 16'hFFFF holds the value.

## Configuration
- FRAME_RX_TIMEOUT_EN defined:
  - A 16-bit gap counter clears on every byte event and counts while the FSM is in any state other than H0/H1.
  - Reaching TIMEOUT gives `cmd_err` with err_code 3 and `err_cnt`+1, then H0.
  - Any read still pending completes normally and its byte is evaluated in H0.
- FRAME_RX_TIMEOUT_EN undefined: no gap counter; a partial frame waits indefinitely; err_code 3 never occurs.

## Test plan
- Good baud frame.
  - Stimulus: bytes EB 90 01 02 00 60 63.
  - Response: `pl_wen` twice (addr 0 = 0x00, addr 1 = 0x60); `cmd_valid` and `latch_baud` together; `baud_word` = 16'h0060; `frame_cnt` = 1.
- Bad checksum.
  - Stimulus: bytes EB 90 05 01 AA B1.
  - Response: `cmd_err` with err_code 1; `err_cnt` = 1; no `cmd_valid`.
- Length check.
  - Stimulus: bytes EB 90 07 21 with MAX_LEN = 32.
  - Response: `cmd_err` with err_code 2 on the LEN byte; no `pl_wen`.
  - Then bytes EB 90 07 00 07 gives `cmd_valid` with `cmd_len` = 0.
- Sync recovery.
  - Stimulus: bytes 55 EB EB 90 03 00 03.
  - Response: one `cmd_valid` with `cmd_code` = 0x03.
- Timeout (FRAME_RX_TIMEOUT_EN defined, TIMEOUT = 100).
  - Stimulus: bytes EB 90 04 03 AA, then the FIFO stays empty for 150 cycles.
  - Response: `cmd_err` with err_code 3 at gap count 100.
  - Then a following good frame is decoded normally.
- Reset mid-payload.
  - Stimulus: `rst` low for 1 cycle during the PAY state.
  - Response: all outputs 0; a subsequent good frame gives `cmd_valid` and `frame_cnt` = 1.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: receive-side frame decoder for the host UART link.
// Pops bytes from the UART receive FIFO and looks for frames of the form
// EB 90 <cmd> <len> <payload...> <csum>. Payload bytes are streamed out,
// and good and bad frames are reported. A good baud command is decoded into
// latch_baud/baud_word.
// Optional inter-byte timeout: define FRAME_RX_TIMEOUT_EN to enable it.
module uart_frame_rx #(
  parameter logic [7:0]  HDR0     = 8'hEB,
  parameter logic [7:0]  HDR1     = 8'h90,
  parameter logic [7:0]  MAX_LEN  = 8'd32,
  parameter logic [7:0]  CMD_BAUD = 8'h01,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_ren,
  input  logic [7:0]  rx_fifo_rdata,
  output logic        pl_wen,
  output logic [7:0]  pl_waddr,
  output logic [7:0]  pl_wdata,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [7:0]  cmd_len,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic        latch_baud,
  output logic [15:0] baud_word,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {
    S_H0, S_H1, S_CMD, S_LEN, S_PAY, S_CSUM
  } state_e;

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_e      state_q;
  logic        pending_q;   // a read was issued last cycle; its byte is on rdata now
  logic [7:0]  code_q;      // working copies for the frame in progress
  logic [7:0]  len_q;
  logic [7:0]  idx_q;
  logic [7:0]  sum_q;
  logic [7:0]  pay0_q;
  logic [7:0]  pay1_q;

  logic        pl_wen_q;
  logic [7:0]  pl_waddr_q;
  logic [7:0]  pl_wdata_q;
  logic        cmd_valid_q;
  logic [7:0]  cmd_code_q;
  logic [7:0]  cmd_len_q;
  logic        cmd_err_q;
  logic [1:0]  err_code_q;
  logic        latch_baud_q;
  logic [15:0] baud_word_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  logic [15:0] frame_cnt_d;
  logic [15:0] err_cnt_d;
  logic        byte_event;

  // Read strobe: one read outstanding at most, suppressed while in reset so
  // no byte is popped that the reset would then discard.
  assign rx_fifo_ren = rst && !rx_fifo_empty && !pending_q;
  assign byte_event  = pending_q;

  // Saturating next values of the two statistics counters.
  assign frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
  assign err_cnt_d   = (err_cnt_q   == 16'hFFFF) ? err_cnt_q   : err_cnt_q   + 16'd1;

`ifdef FRAME_RX_TIMEOUT_EN
  logic [15:0] gap_q;
  logic        timeout_hit;
  // Fires on the cycle the gap counter would reach TIMEOUT inside a frame body.
  assign timeout_hit = (state_q != S_H0) && (state_q != S_H1) &&
                       (gap_q == TIMEOUT - 16'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Read engine: remember that a read was issued so its data is taken next cycle.
  always_ff @(posedge clk) begin
    if (!rst) pending_q <= 1'b0;
    else      pending_q <= rx_fifo_ren;
  end

  // Frame FSM with registered strobes, captured fields and statistics.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch
    // below sees the values from before this clock edge.
    if (!rst) begin
      state_q      <= S_H0;
      code_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      pay0_q       <= '0;
      pay1_q       <= '0;
      pl_wen_q     <= 1'b0;
      pl_waddr_q   <= '0;
      pl_wdata_q   <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
      cmd_len_q    <= '0;
      cmd_err_q    <= 1'b0;
      err_code_q   <= '0;
      latch_baud_q <= 1'b0;
      baud_word_q  <= '0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
`ifdef FRAME_RX_TIMEOUT_EN
      gap_q        <= '0;
`endif
    end else begin
      pl_wen_q     <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      latch_baud_q <= 1'b0;
`ifdef FRAME_RX_TIMEOUT_EN
      if (byte_event || state_q == S_H0 || state_q == S_H1 || timeout_hit) gap_q <= '0;
      else                                                                 gap_q <= gap_q + 16'd1;
`endif
      if (byte_event) begin
        unique case (state_q)
          S_H0: if (rx_fifo_rdata == HDR0) state_q <= S_H1;
          S_H1: begin
            if (rx_fifo_rdata == HDR1)      state_q <= S_CMD;
            else if (rx_fifo_rdata != HDR0) state_q <= S_H0;
          end
          S_CMD: begin
            code_q  <= rx_fifo_rdata;
            sum_q   <= rx_fifo_rdata;
            state_q <= S_LEN;
          end
          S_LEN: begin
            sum_q <= sum_q + rx_fifo_rdata;
            len_q <= rx_fifo_rdata;
            idx_q <= '0;
            if (rx_fifo_rdata > MAX_LEN) begin
              cmd_err_q  <= 1'b1;
              err_code_q <= ERR_LEN;
              err_cnt_q  <= err_cnt_d;
              state_q    <= S_H0;
            end else if (rx_fifo_rdata == 8'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_PAY;
            end
          end
          S_PAY: begin
            pl_wen_q   <= 1'b1;
            pl_waddr_q <= idx_q;
            pl_wdata_q <= rx_fifo_rdata;
            sum_q      <= sum_q + rx_fifo_rdata;
            if (idx_q == 8'd0) pay0_q <= rx_fifo_rdata;
            if (idx_q == 8'd1) pay1_q <= rx_fifo_rdata;
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= S_CSUM;
          end
          S_CSUM: begin
            if (rx_fifo_rdata == sum_q) begin
              cmd_valid_q <= 1'b1;
              cmd_code_q  <= code_q;
              cmd_len_q   <= len_q;
              frame_cnt_q <= frame_cnt_d;
              if (code_q == CMD_BAUD && len_q == 8'd2) begin
                latch_baud_q <= 1'b1;
                baud_word_q  <= {pay0_q, pay1_q};
              end
            end else begin
              cmd_err_q  <= 1'b1;
              err_code_q <= ERR_CSUM;
              err_cnt_q  <= err_cnt_d;
            end
            state_q <= S_H0;
          end
          default: state_q <= S_H0;
        endcase
      end
`ifdef FRAME_RX_TIMEOUT_EN
      else if (timeout_hit) begin
        cmd_err_q  <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        err_cnt_q  <= err_cnt_d;
        state_q    <= S_H0;
      end
`endif
    end
  end

  assign pl_wen     = pl_wen_q;
  assign pl_waddr   = pl_waddr_q;
  assign pl_wdata   = pl_wdata_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_len    = cmd_len_q;
  assign cmd_err    = cmd_err_q;
  assign err_code   = err_code_q;
  assign latch_baud = latch_baud_q;
  assign baud_word  = baud_word_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed, table-driven bench for uart_frame_rx.
// A byte-stream FIFO model feeds the decoder; a negedge monitor records
// strobes and payload writes, and each frame is compared with hand-computed
// expectations.
module tb_uart_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_fifo_empty;
  logic        rx_fifo_ren;
  logic [7:0]  rx_fifo_rdata = 8'h00;
  logic        pl_wen;
  logic [7:0]  pl_waddr;
  logic [7:0]  pl_wdata;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [7:0]  cmd_len;
  logic        cmd_err;
  logic [1:0]  err_code;
  logic        latch_baud;
  logic [15:0] baud_word;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  uart_frame_rx #(.TIMEOUT(16'd100)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_ren   (rx_fifo_ren),
    .rx_fifo_rdata (rx_fifo_rdata),
    .pl_wen        (pl_wen),
    .pl_waddr      (pl_waddr),
    .pl_wdata      (pl_wdata),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_len       (cmd_len),
    .cmd_err       (cmd_err),
    .err_code      (err_code),
    .latch_baud    (latch_baud),
    .baud_word     (baud_word),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt)
  );

  // FIFO model: bytes are appended by the test, popped on rx_fifo_ren.
  logic [7:0] stream [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rx_fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rx_fifo_ren) begin
      rx_fifo_rdata <= stream[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pl, n_valid, n_err, n_latch, n_latch_alone;
  int last_ren_cyc, valid_cyc;
  logic [1:0] last_ec;
  logic [7:0] mon_addr [0:63];
  logic [7:0] mon_data [0:63];

  always @(negedge clk) begin
    if (rx_fifo_ren) last_ren_cyc = cyc;
    if (pl_wen) begin
      if (n_pl < 64) begin
        mon_addr[n_pl] = pl_waddr;
        mon_data[n_pl] = pl_wdata;
      end
      n_pl++;
    end
    if (cmd_valid) begin
      n_valid++;
      valid_cyc = cyc;
    end
    if (cmd_err) begin
      n_err++;
      last_ec = err_code;
    end
    if (latch_baud) begin
      n_latch++;
      if (!cmd_valid) n_latch_alone++;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_pl = 0; n_valid = 0; n_err = 0; n_latch = 0; n_latch_alone = 0;
    last_ec = 2'd0; last_ren_cyc = 0; valid_cyc = 0;
  endtask

  task automatic push(input logic [7:0] b);
    stream[wr_ptr] = b;
    wr_ptr++;
  endtask

  // Wait (bounded) for the FIFO to drain, let the pipeline settle, then
  // leave the caller on a negedge.
  task automatic drain(input string name);
    int k = 0;
    while (rd_ptr != wr_ptr && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 1000) check({name, "_drain_timeout"}, 32'd1, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int          n;
    logic [7:0]  b [8];
    int          e_valid;
    int          e_err;
    logic [1:0]  e_ec;
    int          e_latch;
    int          e_npl;
    logic [7:0]  e_pl0;
    logic [7:0]  e_pl1;
    logic [7:0]  e_code;
    logic [7:0]  e_len;
    logic [15:0] e_baud;
    logic [15:0] e_fc;
    logic [15:0] e_ecnt;
  } vec_t;

  vec_t vec [7];

  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    for (int j = 0; j < v.n; j++) push(v.b[j]);
    drain(p);
    check({p, "_valid"}, n_valid, v.e_valid);
    check({p, "_err"}, n_err, v.e_err);
    if (v.e_err > 0) check({p, "_err_code"}, last_ec, v.e_ec);
    check({p, "_latch"}, n_latch, v.e_latch);
    check({p, "_latch_without_valid"}, n_latch_alone, 0);
    check({p, "_pl_count"}, n_pl, v.e_npl);
    if (v.e_npl >= 1) begin
      check({p, "_pl0_addr"}, mon_addr[0], 8'd0);
      check({p, "_pl0_data"}, mon_data[0], v.e_pl0);
    end
    if (v.e_npl >= 2) begin
      check({p, "_pl1_addr"}, mon_addr[1], 8'd1);
      check({p, "_pl1_data"}, mon_data[1], v.e_pl1);
    end
    check({p, "_cmd_code"}, cmd_code, v.e_code);
    check({p, "_cmd_len"}, cmd_len, v.e_len);
    check({p, "_baud_word"}, baud_word, v.e_baud);
    check({p, "_frame_cnt"}, frame_cnt, v.e_fc);
    check({p, "_err_cnt"}, err_cnt, v.e_ecnt);
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_ren"}, rx_fifo_ren, 0);
    check({p, "_pl_wen"}, pl_wen, 0);
    check({p, "_pl_waddr"}, pl_waddr, 0);
    check({p, "_pl_wdata"}, pl_wdata, 0);
    check({p, "_cmd_valid"}, cmd_valid, 0);
    check({p, "_cmd_code"}, cmd_code, 0);
    check({p, "_cmd_len"}, cmd_len, 0);
    check({p, "_cmd_err"}, cmd_err, 0);
    check({p, "_err_code"}, err_code, 0);
    check({p, "_latch_baud"}, latch_baud, 0);
    check({p, "_baud_word"}, baud_word, 0);
    check({p, "_frame_cnt"}, frame_cnt, 0);
    check({p, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    int mism;
    // Directed frames, applied back to back without reset; counters accumulate.
    // Good baud frame: sum 01+02+00+60 = 63.
    vec[0] = '{7, '{8'hEB, 8'h90, 8'h01, 8'h02, 8'h00, 8'h60, 8'h63, 8'h00},
               1, 0, 2'd0, 1, 2, 8'h00, 8'h60, 8'h01, 8'h02, 16'h0060, 16'd1, 16'd0};
    // Bad checksum: sum 05+01+AA = B0, received B1.
    vec[1] = '{6, '{8'hEB, 8'h90, 8'h05, 8'h01, 8'hAA, 8'hB1, 8'h00, 8'h00},
               0, 1, 2'd1, 0, 1, 8'hAA, 8'h00, 8'h01, 8'h02, 16'h0060, 16'd1, 16'd1};
    // Length 33 > MAX_LEN.
    vec[2] = '{4, '{8'hEB, 8'h90, 8'h07, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00},
               0, 1, 2'd2, 0, 0, 8'h00, 8'h00, 8'h01, 8'h02, 16'h0060, 16'd1, 16'd2};
    // Zero-length frame.
    vec[3] = '{5, '{8'hEB, 8'h90, 8'h07, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00},
               1, 0, 2'd0, 0, 0, 8'h00, 8'h00, 8'h07, 8'h00, 16'h0060, 16'd2, 16'd2};
    // Sync recovery through junk and a repeated HDR0.
    vec[4] = '{7, '{8'h55, 8'hEB, 8'hEB, 8'h90, 8'h03, 8'h00, 8'h03, 8'h00},
               1, 0, 2'd0, 0, 0, 8'h00, 8'h00, 8'h03, 8'h00, 16'h0060, 16'd3, 16'd2};
    // CMD_BAUD with length 1: good frame, no latch, baud_word held.
    vec[5] = '{6, '{8'hEB, 8'h90, 8'h01, 8'h01, 8'h12, 8'h14, 8'h00, 8'h00},
               1, 0, 2'd0, 0, 1, 8'h12, 8'h00, 8'h01, 8'h01, 16'h0060, 16'd4, 16'd2};
    // Baud frame with distinct bytes checks big-endian order: sum = 49.
    vec[6] = '{7, '{8'hEB, 8'h90, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49, 8'h00},
               1, 0, 2'd0, 1, 2, 8'h12, 8'h34, 8'h01, 8'h02, 16'h1234, 16'd5, 16'd2};

    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vec[i]);
      if (i == 0) check("v0_csum_ren_to_valid", valid_cyc - last_ren_cyc, 2);
    end

    // Maximum legal length: 32 payload bytes 0..31, cmd 10.
    // Sum = 10 + 20 + 1F0 = 220 -> 20.
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    push(8'hEB); push(8'h90); push(8'h10); push(8'h20);
    for (int j = 0; j < 32; j++) push(8'(j));
    push(8'h20);
    drain("maxlen");
    mism = 0;
    for (int j = 0; j < 32; j++)
      if (mon_addr[j] !== 8'(j) || mon_data[j] !== 8'(j)) mism++;
    check("maxlen_pl_count", n_pl, 32);
    check("maxlen_pl_content", mism, 0);
    check("maxlen_valid", n_valid, 1);
    check("maxlen_err", n_err, 0);
    check("maxlen_cmd_len", cmd_len, 8'h20);
    check("maxlen_frame_cnt", frame_cnt, 16'd6);

    // Partial frame followed by a 150-cycle FIFO gap.
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    push(8'hEB); push(8'h90); push(8'h04); push(8'h03); push(8'hAA);
    drain("gap");
    check("gap_no_early_err", n_err, 0);
    idle(150);
`ifdef FRAME_RX_TIMEOUT_EN
    check("timeout_err", n_err, 1);
    check("timeout_err_code", last_ec, 2'd3);
    check("timeout_err_cnt", err_cnt, 16'd3);
    check("timeout_no_valid", n_valid, 0);
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    push(8'hEB); push(8'h90); push(8'h03); push(8'h00); push(8'h03);
    drain("after_timeout");
    check("after_timeout_valid", n_valid, 1);
    check("after_timeout_code", cmd_code, 8'h03);
    check("after_timeout_frame_cnt", frame_cnt, 16'd7);
`else
    // Without the timeout the frame simply resumes: 04+03+AA+BB+CC = 38.
    check("stall_no_err", n_err, 0);
    push(8'hBB); push(8'hCC); push(8'h38);
    drain("stall_resume");
    check("stall_valid", n_valid, 1);
    check("stall_err", n_err, 0);
    check("stall_code", cmd_code, 8'h04);
    check("stall_len", cmd_len, 8'h03);
    check("stall_frame_cnt", frame_cnt, 16'd7);
    check("stall_err_cnt", err_cnt, 16'd2);
`endif

    // Reset in the middle of a payload.
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    push(8'hEB); push(8'h90); push(8'h05); push(8'h04); push(8'h11); push(8'h22);
    drain("midpay");
    check("midpay_pl_count", n_pl, 2);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b1;
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    push(8'hEB); push(8'h90); push(8'h03); push(8'h00); push(8'h03);
    drain("post_reset");
    check("post_reset_valid", n_valid, 1);
    check("post_reset_err", n_err, 0);
    check("post_reset_code", cmd_code, 8'h03);
    check("post_reset_frame_cnt", frame_cnt, 16'd1);
    check("post_reset_err_cnt", err_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
